imem_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the always-requesting, fixed-step PC register with a real `imem` request/acknowledge handshake. It also adds:
- a prefetch instruction FIFO;
- consumer back-pressure;
- control-flow redirect with safe discard of in-flight responses.

It sits between instruction memory and the instruction decoder. The decoder consumes `{pc, instruction}` pairs through a valid/ready port.

---
 rtl/imem_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_imem_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - instruction fetch front end with imem handshake, prefetch FIFO and redirect
//
// Sits between instruction memory and the decoder. It issues one outstanding
// request at a time on the imem port, buffers returned instructions together
// with their fetch address in a small FIFO, and hands {pc, instruction} pairs
// to the decoder over a valid/ready port. A redirect flushes the FIFO and
// restarts fetch at a new address. If a request is still outstanding at that
// point, its response is drained and discarded first.
//
// Ports:
//   clk_i, arst_ni      clock (rising edge), asynchronous active-low reset
//   boot_addr_i         first fetch address, sampled on the first edge after reset
//   imem_req_o/addr_o   fetch request and address, held until imem_ack_i
//   imem_rdata_i/ack_i  returned instruction, completion strobe
//   redirect_i/addr_i   flush pulse and new fetch target (low bits forced to 0)
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i   decoder-side FIFO head
module imem_fetch_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 16,
    parameter int PC_STEP     = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   arst_ni,
    input  logic [ADDR_WIDTH-1:0]  boot_addr_i,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    input  logic                   imem_ack_i,
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr_i,
    output logic                   instr_valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  instr_pc_o,
    input  logic                   instr_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] STEP_MASK = ADDR_WIDTH'(PC_STEP - 1);
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(FIFO_DEPTH);

    logic [1:0]             state;
    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  hold_pc;
    logic [ADDR_WIDTH-1:0]  target;
    logic [CNT_W-1:0]       count;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [ADDR_WIDTH-1:0]  pc_mem    [FIFO_DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [FIFO_DEPTH];

    logic full;
    logic req_done;
    logic push;
    logic pop;
    logic flush;

    // Redirect targets are aligned to the instruction step.
    assign target = redirect_addr_i & ~STEP_MASK;

    assign full = (count == CNT_FULL);

    // Request and address come only from registered state. In FETCH the
    // request can only drop via a push (which needs an ack), so an issued
    // request is never withdrawn before it completes. DRAIN keeps the
    // pre-redirect request on the bus until its ack arrives.
    assign imem_req_o  = ((state == ST_FETCH) && !full) || (state == ST_DRAIN);
    assign imem_addr_o = (state == ST_FETCH) ? fetch_pc :
                         (state == ST_DRAIN) ? hold_pc  : '0;

    assign req_done = imem_req_o && imem_ack_i;
    assign push     = req_done && (state == ST_FETCH) && !redirect_i;
    assign pop      = instr_valid_o && instr_ready_i;
    assign flush    = redirect_i && (state != ST_BOOT);

    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_mem[rd_ptr];
    assign instr_pc_o    = pc_mem[rd_ptr];

    // Fetch control state machine.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state    <= ST_BOOT;
            fetch_pc <= '0;
            hold_pc  <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    fetch_pc <= boot_addr_i;
                    state    <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (redirect_i) begin
                        fetch_pc <= target;
                        // Request still outstanding: remember its address so it
                        // stays on the bus while we wait to throw the data away.
                        if (imem_req_o && !imem_ack_i) begin
                            hold_pc <= fetch_pc;
                            state   <= ST_DRAIN;
                        end
                    end else if (push) begin
                        fetch_pc <= fetch_pc + STEP;
                    end
                end
                ST_DRAIN: begin
                    if (redirect_i) begin
                        fetch_pc <= target;
                    end
                    if (imem_ack_i) begin
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

    // FIFO occupancy and pointers. Pointer width equals log2(depth), so the
    // increment wraps modulo FIFO_DEPTH by itself.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // FIFO storage. Cleared on reset so the head outputs read zero after reset.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb/tb_imem_fetch_unit.sv - directed self-checking bench for imem_fetch_unit
module tb_imem_fetch_unit;

    logic        clk;
    logic        arst_n;
    logic [31:0] boot_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        instr_valid;
    logic [15:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int checks = 0;
    int errors = 0;

    imem_fetch_unit #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(16),
        .PC_STEP    (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i          (clk),
        .arst_ni        (arst_n),
        .boot_addr_i    (boot_addr),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_rdata_i   (imem_rdata),
        .imem_ack_i     (imem_ack),
        .redirect_i     (redirect),
        .redirect_addr_i(redirect_addr),
        .instr_valid_o  (instr_valid),
        .instr_o        (instr),
        .instr_pc_o     (instr_pc),
        .instr_ready_i  (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // Instruction memory: word content is a fixed function of the address.
    assign imem_rdata = mem_word(imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] boot);
        arst_n        = 1'b0;
        imem_ack      = 1'b0;
        instr_ready   = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        step();
        boot_addr = boot;
        arst_n    = 1'b1;
        step();
    endtask

    task automatic test_reset();
        arst_n        = 1'b0;
        boot_addr     = 32'h100;
        imem_ack      = 1'b0;
        instr_ready   = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        #3;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (instr !== 16'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", instr_pc); end
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_hold_req got %b exp 0", imem_req); end
    endtask

    task automatic test_boot_stream();
        do_reset(32'h100);
        instr_ready = 1'b1;
        imem_ack    = 1'b1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL boot_first_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL boot_first_addr got %h exp 100", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL boot_empty got %b exp 0", instr_valid); end
        step();
        for (int i = 0; i < 6; i++) begin
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, instr_valid); end
            checks++; if (instr_pc !== 32'h100 + 32'(2 * i)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, instr_pc, 32'h100 + 32'(2 * i)); end
            checks++; if (instr !== mem_word(32'h100 + 32'(2 * i))) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, instr, mem_word(32'h100 + 32'(2 * i))); end
            step();
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset(32'h100);
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req got %b exp 0", imem_req); end
        checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL bp_head_pc got %h exp 100", instr_pc); end
        checks++; if (instr !== 16'hA4A5) begin errors++; $display("FAIL bp_head_instr got %h exp a4a5", instr); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_stall_req[%0d] got %b exp 0", i, imem_req); end
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL bp_resume_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h108) begin errors++; $display("FAIL bp_resume_addr got %h exp 108", imem_addr); end
        checks++; if (instr_pc !== 32'h102) begin errors++; $display("FAIL bp_after_pop_pc got %h exp 102", instr_pc); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_refull_req[%0d] got %b exp 0", i, imem_req); end
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (instr_pc !== 32'h102 + 32'(2 * i)) begin errors++; $display("FAIL bp_drain_pc[%0d] got %h exp %h", i, instr_pc, 32'h102 + 32'(2 * i)); end
            step();
        end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_drained_valid got %b exp 0", instr_valid); end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        do_reset(32'h100);
        instr_ready   = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 32'h400;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rw_hold_req[%0d] got %b exp 1", i, imem_req); end
            checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rw_hold_addr[%0d] got %h exp 100", i, imem_addr); end
            step();
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped_valid got %b exp 0", instr_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rw_new_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h400) begin errors++; $display("FAIL rw_new_addr got %h exp 400", imem_addr); end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_pc !== 32'h400) begin errors++; $display("FAIL rw_first_pc got %h exp 400", instr_pc); end
        checks++; if (instr !== 16'hA1A5) begin errors++; $display("FAIL rw_first_instr got %h exp a1a5", instr); end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_ack();
        do_reset(32'h200);
        instr_ready   = 1'b1;
        imem_ack      = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 32'h203;
        step();
        redirect = 1'b0;
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ra_dropped_valid got %b exp 0", instr_valid); end
        checks++; if (imem_addr !== 32'h202) begin errors++; $display("FAIL ra_next_addr got %h exp 202", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ra_next_req got %b exp 1", imem_req); end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_pc !== 32'h202) begin errors++; $display("FAIL ra_first_pc got %h exp 202", instr_pc); end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_flush();
        do_reset(32'h100);
        imem_ack = 1'b1;
        step();
        step();
        checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL rf_head_pc got %h exp 100", instr_pc); end
        redirect      = 1'b1;
        redirect_addr = 32'h300;
        step();
        redirect = 1'b0;
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rf_flushed_valid got %b exp 0", instr_valid); end
        checks++; if (imem_addr !== 32'h300) begin errors++; $display("FAIL rf_next_addr got %h exp 300", imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset(32'hFFFF_FFFE);
        instr_ready = 1'b1;
        imem_ack    = 1'b1;
        step();
        checks++; if (instr_pc !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_pc0 got %h exp fffffffe", instr_pc); end
        checks++; if (instr !== 16'h5A5B) begin errors++; $display("FAIL wrap_instr0 got %h exp 5a5b", instr); end
        step();
        imem_ack = 1'b0;
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc1 got %h exp 0", instr_pc); end
        checks++; if (instr !== 16'hA5A5) begin errors++; $display("FAIL wrap_instr1 got %h exp a5a5", instr); end
        instr_ready = 1'b0;
    endtask

    task automatic test_reset_in_drain();
        do_reset(32'h100);
        instr_ready   = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 32'h500;
        step();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rd_drain_addr got %h exp 100", imem_addr); end
        arst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_async_req got %b exp 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rd_async_addr got %h exp 0", imem_addr); end
        boot_addr = 32'h600;
        imem_ack  = 1'b1;
        step();
        arst_n = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_stale_ack_valid got %b exp 0", instr_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rd_restart_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h600) begin errors++; $display("FAIL rd_restart_addr got %h exp 600", imem_addr); end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_pc !== 32'h600) begin errors++; $display("FAIL rd_first_pc got %h exp 600", instr_pc); end
    endtask

    initial begin
        test_reset();
        test_boot_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack();
        test_redirect_flush();
        test_wrap();
        test_reset_in_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
